// File: rtl/qu_common.sv
// -----------------------------------------------------------------------------
// qu_common
// Types and constants shared by the reorder buffer blocks.
//   ROB_DEPTH          : number of reorder buffer entries (power of two)
//   rob_addr_t         : entry index; wraps naturally at ROB_DEPTH
//   rob_cell_t         : one storage cell (valid/ready/exception flags,
//                        destination register, result value, pc)
//   rob_commit_state_t : states of the allocation/retire controller
//   rob_ptr_inc        : circular pointer increment
// -----------------------------------------------------------------------------
package qu_common;

   localparam int ROB_DEPTH = 32;
   localparam int ROB_AW    = $clog2(ROB_DEPTH);

   typedef logic [ROB_AW-1:0] rob_addr_t;

   typedef struct packed {
      logic        valid;
      logic        ready;
      logic        exception;
      logic [4:0]  rd_addr;
      logic [31:0] value;
      logic [31:0] pc;
   } rob_cell_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } rob_commit_state_t;

   // ROB_DEPTH is a power of two, so the wrap from ROB_DEPTH-1 to 0 is the
   // natural overflow of the index width.
   function automatic rob_addr_t rob_ptr_inc(input rob_addr_t p);
      return p + rob_addr_t'(1);
   endfunction

endpackage

// File: rtl/rob_commit.sv
// -----------------------------------------------------------------------------
// rob_commit
// In-order allocation and retirement controller for the reorder buffer
// storage. Owns head/tail pointers and the occupancy count, writes newly
// allocated cells through storage write port 1, reads the head cell through
// read port 1 and clears retired/flushed cells through write port 3.
// A faulting head entry starts a flush that invalidates every occupied entry,
// one per cycle, then returns both pointers to 0.
//
// Ports
//   clk                      : clock, rising edge
//   rst                      : synchronous reset, active low
//   alloc_req / alloc_cell   : dispatch request and the cell to write
//   alloc_gnt / alloc_tag    : combinational grant and granted index (tail)
//   wr1_en/addr/in           : allocation write to storage
//   rd1_addr / rd1_out       : head (or flush pointer) read, combinational data
//   wr3_en/addr/in           : invalidation write (all-zero cell)
//   commit_valid/rd/value    : registered retire pulse and retired payload
//   flush                    : registered pulse when a fault reaches head
//   full / empty / count     : occupancy status
//
// The storage must have ROB_DEPTH entries addressed by rob_addr_t, so
// ROB_DEPTH has to match the width of rob_addr_t in qu_common.
// -----------------------------------------------------------------------------
module rob_commit
   import qu_common::*;
#(
   parameter int ROB_DEPTH = qu_common::ROB_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         alloc_req,
   input  rob_cell_t                    alloc_cell,
   output logic                         alloc_gnt,
   output rob_addr_t                    alloc_tag,
   output logic                         wr1_en,
   output rob_addr_t                    wr1_addr,
   output rob_cell_t                    wr1_in,
   output rob_addr_t                    rd1_addr,
   input  rob_cell_t                    rd1_out,
   output logic                         wr3_en,
   output rob_addr_t                    wr3_addr,
   output rob_cell_t                    wr3_in,
   output logic                         commit_valid,
   output logic [4:0]                   commit_rd,
   output logic [31:0]                  commit_value,
   output logic                         flush,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(ROB_DEPTH):0]   count
);

   localparam int CW = $clog2(ROB_DEPTH) + 1;

   rob_commit_state_t state_q;

   rob_addr_t         head_q,  head_d;
   rob_addr_t         tail_q,  tail_d;
   rob_addr_t         fptr_q,  fptr_d;
   logic [CW-1:0]     count_q, count_d;

   logic              commit_valid_q;
   logic [4:0]        commit_rd_q;
   logic [31:0]       commit_value_q;
   logic              flush_q;

   logic              in_flush;
   logic              head_done;
   logic              do_retire;
   logic              do_fault;
   logic              do_alloc;
   logic              flush_step;
   logic              flush_last;
   logic              full_w;

   // The pc field travels with the cell but is not needed for retirement.
   logic              unused_pc;
   assign unused_pc = ^rd1_out.pc;

   // ------------------------------------------------------------------
   // Decode of the current cycle
   // ------------------------------------------------------------------
   always_comb begin
      in_flush   = (state_q == ST_FLUSH);
      full_w     = (count_q == CW'(ROB_DEPTH));

      // The head cell is only meaningful in RUN, where count is non-zero;
      // in IDLE the read data is stale and must be ignored.
      head_done  = rst && (state_q == ST_RUN) && rd1_out.valid && rd1_out.ready;
      do_retire  = head_done && !rd1_out.exception;
      do_fault   = head_done &&  rd1_out.exception;

      // A full buffer refuses allocation even if the head retires this
      // cycle; the freed slot is granted on the following cycle.
      do_alloc   = rst && alloc_req && !full_w && !in_flush;

      flush_step = rst && in_flush && (count_q != '0);
      flush_last = flush_step && (count_q == CW'(1));
   end

   // ------------------------------------------------------------------
   // Pointer and occupancy next state
   // ------------------------------------------------------------------
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      fptr_d  = fptr_q;
      count_d = count_q;

      if (do_alloc) begin
         tail_d = rob_ptr_inc(tail_q);
      end
      if (do_retire) begin
         head_d = rob_ptr_inc(head_q);
      end

      // Grant and retire in the same cycle cancel out.
      if (do_alloc && !do_retire) begin
         count_d = count_q + CW'(1);
      end else if (do_retire && !do_alloc) begin
         count_d = count_q - CW'(1);
      end

      // The flush walk starts at the faulting head and consumes one
      // occupied entry per cycle.
      if (do_fault) begin
         fptr_d = head_q;
      end
      if (flush_step) begin
         fptr_d  = rob_ptr_inc(fptr_q);
         count_d = count_q - CW'(1);
      end
      if (flush_last) begin
         head_d = '0;
         tail_d = '0;
      end
   end

   // ------------------------------------------------------------------
   // FSM and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         head_q         <= '0;
         tail_q         <= '0;
         fptr_q         <= '0;
         count_q        <= '0;
         commit_valid_q <= 1'b0;
         commit_rd_q    <= '0;
         commit_value_q <= '0;
         flush_q        <= 1'b0;
      end else begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         fptr_q         <= fptr_d;
         count_q        <= count_d;
         commit_valid_q <= do_retire;
         flush_q        <= do_fault;

         if (do_retire) begin
            commit_rd_q    <= rd1_out.rd_addr;
            commit_value_q <= rd1_out.value;
         end

         case (state_q)
            ST_IDLE: begin
               if (count_d != '0) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (do_fault) begin
                  state_q <= ST_FLUSH;
               end else if (count_d == '0) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_FLUSH: begin
               // The count check covers a flush entered with nothing left.
               if (flush_last || (count_q == '0)) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Storage port drive and status outputs
   // ------------------------------------------------------------------
   assign alloc_gnt    = do_alloc;
   assign alloc_tag    = tail_q;

   assign wr1_en       = do_alloc;
   assign wr1_addr     = tail_q;
   assign wr1_in       = alloc_cell;

   // During FLUSH the read port follows the flush pointer instead of head.
   assign rd1_addr     = in_flush ? fptr_q : head_q;

   assign wr3_en       = do_retire || flush_step;
   assign wr3_addr     = in_flush ? fptr_q : head_q;
   assign wr3_in       = '0;

   assign commit_valid = commit_valid_q;
   assign commit_rd    = commit_rd_q;
   assign commit_value = commit_value_q;
   assign flush        = flush_q;

   assign full         = full_w;
   assign empty        = (count_q == '0);
   assign count        = count_q;

endmodule

// File: tb/tb_rob_commit.sv
// -----------------------------------------------------------------------------
// tb_rob_commit
// Self-checking bench for rob_commit. A behavioural storage array supplies
// the combinational head read and absorbs the allocation, completion and
// invalidation writes. Expected commits and expected invalidation addresses
// are queued when completions are driven and popped by a monitor whenever
// the DUT produces a commit pulse or a wr3 write.
// -----------------------------------------------------------------------------
module tb_rob_commit;
   import qu_common::*;

   localparam int D  = ROB_DEPTH;
   localparam int CW = $clog2(D) + 1;

   logic            clk;
   logic            rst;
   logic            alloc_req;
   rob_cell_t       alloc_cell;
   logic            alloc_gnt;
   rob_addr_t       alloc_tag;
   logic            wr1_en;
   rob_addr_t       wr1_addr;
   rob_cell_t       wr1_in;
   rob_addr_t       rd1_addr;
   rob_cell_t       rd1_out;
   logic            wr3_en;
   rob_addr_t       wr3_addr;
   rob_cell_t       wr3_in;
   logic            commit_valid;
   logic [4:0]      commit_rd;
   logic [31:0]     commit_value;
   logic            flush;
   logic            full;
   logic            empty;
   logic [CW-1:0]   count;

   // completion port (storage write port 2), driven by the bench
   logic            cpl_en;
   rob_addr_t       cpl_addr;
   logic [31:0]     cpl_val;
   logic            cpl_exc;

   rob_cell_t       mem [D];

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] val;
   } exp_commit_t;

   exp_commit_t     commit_q[$];
   rob_addr_t       inv_q[$];

   int              n_checks = 0;
   int              n_errors = 0;

   rob_commit #(.ROB_DEPTH(D)) dut (
      .clk          (clk),
      .rst          (rst),
      .alloc_req    (alloc_req),
      .alloc_cell   (alloc_cell),
      .alloc_gnt    (alloc_gnt),
      .alloc_tag    (alloc_tag),
      .wr1_en       (wr1_en),
      .wr1_addr     (wr1_addr),
      .wr1_in       (wr1_in),
      .rd1_addr     (rd1_addr),
      .rd1_out      (rd1_out),
      .wr3_en       (wr3_en),
      .wr3_addr     (wr3_addr),
      .wr3_in       (wr3_in),
      .commit_valid (commit_valid),
      .commit_rd    (commit_rd),
      .commit_value (commit_value),
      .flush        (flush),
      .full         (full),
      .empty        (empty),
      .count        (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- storage model ----------------
   initial begin
      for (int i = 0; i < D; i++) mem[i] = '0;
   end

   assign rd1_out = mem[rd1_addr];

   always @(posedge clk) begin
      rob_cell_t c;
      if (wr1_en) mem[wr1_addr] <= wr1_in;
      if (cpl_en) begin
         c           = mem[cpl_addr];
         c.ready     = 1'b1;
         c.value     = cpl_val;
         c.exception = cpl_exc;
         mem[cpl_addr] <= c;
      end
      if (wr3_en) mem[wr3_addr] <= wr3_in;
   end

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: samples settled outputs shortly after the falling edge.
   always @(negedge clk) begin
      exp_commit_t e;
      rob_addr_t   a;
      #2;
      if (commit_valid) begin
         if (commit_q.size() == 0) begin
            check_val("commit_unexpected", 64'(commit_valid), 64'd0);
         end else begin
            e = commit_q.pop_front();
            $display("commit rd=%0d value=%0d", commit_rd, commit_value);
            check_val("commit_rd", 64'(commit_rd), 64'(e.rd));
            check_val("commit_value", 64'(commit_value), 64'(e.val));
         end
      end
      if (wr3_en) begin
         if (inv_q.size() == 0) begin
            check_val("wr3_unexpected", 64'(wr3_en), 64'd0);
         end else begin
            a = inv_q.pop_front();
            $display("invalidate addr=%0d", wr3_addr);
            check_val("wr3_addr", 64'(wr3_addr), 64'(a));
            check_val("wr3_data", 64'(wr3_in != '0), 64'd0);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(negedge clk);
      alloc_req = 1'b0;
      cpl_en    = 1'b0;
   endtask

   task automatic alloc_chk(input string tag, input logic [4:0] rd,
                            input logic exp_gnt, input int exp_tag);
      alloc_req  = 1'b1;
      alloc_cell = '{valid: 1'b1, ready: 1'b0, exception: 1'b0,
                     rd_addr: rd, value: 32'd0, pc: 32'h1000 + 32'(rd)};
      #1;
      check_val({tag, "_gnt"}, 64'(alloc_gnt), 64'(exp_gnt));
      if (exp_gnt) begin
         check_val({tag, "_tag"}, 64'(alloc_tag), 64'(exp_tag));
         check_val({tag, "_wr1"}, 64'({wr1_en, wr1_addr}), 64'({1'b1, rob_addr_t'(exp_tag)}));
      end
   endtask

   task automatic set_cpl(input rob_addr_t a, input logic [31:0] v,
                          input logic [4:0] rd, input logic exc);
      cpl_en   = 1'b1;
      cpl_addr = a;
      cpl_val  = v;
      cpl_exc  = exc;
      if (!exc) begin
         commit_q.push_back('{rd: rd, val: v});
         inv_q.push_back(a);
      end
   endtask

   task automatic do_reset();
      step();
      rst = 1'b0;
      alloc_chk("rst_alloc", 5'd1, 1'b0, 0);
      step();
      check_val("rst_count", 64'(count), 64'd0);
      check_val("rst_empty_full", 64'({empty, full}), 64'b10);
      check_val("rst_commit_valid", 64'(commit_valid), 64'd0);
      check_val("rst_flush", 64'(flush), 64'd0);
      check_val("rst_commit_payload", {27'd0, commit_rd, commit_value}, 64'd0);
      check_val("rst_ptrs", 64'({rd1_addr, alloc_tag}), 64'd0);
      rst = 1'b1;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while ((commit_q.size() != 0 || inv_q.size() != 0) && n < budget) begin
         step();
         n++;
      end
      check_val(tag, 64'(commit_q.size() + inv_q.size()), 64'd0);
   endtask

   task automatic wait_flush(input string tag, input int budget);
      int n = 0;
      while (!flush && n < budget) begin
         step();
         n++;
      end
      check_val(tag, 64'(flush), 64'd1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst        = 1'b0;
      alloc_req  = 1'b0;
      alloc_cell = '0;
      cpl_en     = 1'b0;
      cpl_addr   = '0;
      cpl_val    = '0;
      cpl_exc    = 1'b0;

      // 1) reset, three allocations without completion
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         alloc_chk("a3", 5'(i + 1), 1'b1, i);
      end
      step();
      check_val("a3_count", 64'(count), 64'd3);
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("a3_no_commit", 64'(commit_valid), 64'd0);
      end

      // 2) retire entries 0..2 in order
      step(); set_cpl(rob_addr_t'(0), 32'd5, 5'd1, 1'b0);
      step(); set_cpl(rob_addr_t'(1), 32'd6, 5'd2, 1'b0);
      step(); set_cpl(rob_addr_t'(2), 32'd7, 5'd3, 1'b0);
      step();
      wait_drain("drain3", 20);
      check_val("drain3_empty", 64'({empty, count}), 64'({1'b1, CW'(0)}));

      // 3) fill, refuse the 33rd, grant the freed slot one cycle after retire
      do_reset();
      for (int i = 0; i < D; i++) begin
         step();
         alloc_chk("fill", 5'(i), 1'b1, i);
      end
      step();
      check_val("fill_full", 64'({full, count}), 64'({1'b1, CW'(D)}));
      step();
      alloc_chk("over", 5'd9, 1'b0, 0);
      set_cpl(rob_addr_t'(0), 32'hABCD, 5'd0, 1'b0);
      step();
      alloc_chk("over_retire", 5'd9, 1'b0, 0);
      step();
      check_val("freed_count", 64'(count), 64'(D - 1));
      alloc_chk("wrap", 5'd9, 1'b1, 0);
      step();
      check_val("wrap_count", 64'({full, count}), 64'({1'b1, CW'(D)}));
      wait_drain("drain_full", 10);

      // 4) simultaneous retire and allocate at count 10
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step();
         alloc_chk("ten", 5'(i + 1), 1'b1, i);
      end
      step();
      set_cpl(rob_addr_t'(0), 32'd55, 5'd1, 1'b0);
      step();
      alloc_chk("both", 5'd11, 1'b1, 10);
      step();
      check_val("both_count", 64'(count), 64'd10);
      check_val("both_head", 64'(rd1_addr), 64'd1);
      check_val("both_tail", 64'(alloc_tag), 64'd11);
      wait_drain("drain_both", 10);

      // 5) fault on entry 2 of 5
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step();
         alloc_chk("five", 5'(i + 1), 1'b1, i);
      end
      step(); set_cpl(rob_addr_t'(0), 32'd100, 5'd1, 1'b0);
      step(); set_cpl(rob_addr_t'(1), 32'd101, 5'd2, 1'b0);
      step(); set_cpl(rob_addr_t'(2), 32'hDEAD, 5'd3, 1'b1);
      inv_q.push_back(rob_addr_t'(2));
      inv_q.push_back(rob_addr_t'(3));
      inv_q.push_back(rob_addr_t'(4));
      step();
      wait_flush("flush_pulse", 10);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            step();
            check_val("flush_one_cycle", 64'(flush), 64'd0);
         end
         check_val("flush_count", 64'(count), 64'(3 - k));
         alloc_chk("flush_block", 5'd7, 1'b0, 0);
      end
      step();
      check_val("flush_done", 64'({empty, count}), 64'({1'b1, CW'(0)}));
      check_val("flush_ptrs", 64'({rd1_addr, alloc_tag}), 64'd0);
      alloc_chk("post_flush", 5'd7, 1'b1, 0);
      step();
      wait_drain("drain_flush", 5);

      // 6) reset during the second flush cycle
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         alloc_chk("abort", 5'(i + 1), 1'b1, i);
      end
      step();
      set_cpl(rob_addr_t'(0), 32'hBAD, 5'd1, 1'b1);
      inv_q.push_back(rob_addr_t'(0));
      step();
      wait_flush("abort_flush", 10);
      step();
      rst = 1'b0;
      #1;
      check_val("abort_wr3_gated", 64'(wr3_en), 64'd0);
      step();
      check_val("abort_count", 64'({empty, count}), 64'({1'b1, CW'(0)}));
      check_val("abort_flush_low", 64'(flush), 64'd0);
      rst = 1'b1;
      repeat (4) step();
      alloc_chk("abort_idle", 5'd4, 1'b1, 0);
      step();
      wait_drain("drain_abort", 5);

      repeat (2) step();
      check_val("final_queues", 64'(commit_q.size() + inv_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
